// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph table (active-high, index = hex value),
// idle/blank codes and the scan-decoder FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [7:0] AN_NONE   = 8'hFF;

  // Entry i is the {g,f,e,d,c,b,a} lit pattern for hex digit i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCapture,
    StHold
  } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph decoder: active-low segment bus to hex nibble with
// valid and blank flags.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg7,
  output logic [3:0] nibble,
  output logic       ok,
  output logic       blank
);

  logic [6:0] lit;

  always_comb begin
    lit    = ~seg7;
    nibble = 4'h0;
    ok     = 1'b0;
    blank  = (lit == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (lit == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        ok     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed seven-segment scan bus and rebuilds the 8-digit frame.
// Optional SEG7_ERR_COUNT_EN adds a saturating decode-error counter output.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [6:0]  seg7,
  output logic [31:0] digits,
  output logic [7:0]  digit_ok,
  output logic [7:0]  digit_blank,
  output logic        frame_done,
  output logic        decode_err,
  output logic        scan_stall
`ifdef SEG7_ERR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int unsigned   ToW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    StabMax = 8'(STABLE_CYCLES);
  localparam logic [ToW-1:0] ToMax  = ToW'(TIMEOUT_CYCLES);

  scan_state_e state_q, state_d;

  logic [7:0]     an_q, cap_an_q;
  logic [6:0]     seg_q, cap_seg_q;
  logic [7:0]     stab_q;
  logic [7:0]     seen_q, seen_d;
  logic [31:0]    buf_nib_q, buf_nib_d;
  logic [7:0]     buf_ok_q, buf_ok_d;
  logic [7:0]     buf_blank_q, buf_blank_d;
  logic [31:0]    digits_q;
  logic [7:0]     ok_q, blank_q;
  logic           frame_done_q, decode_err_q, err_d;
  logic [ToW-1:0] to_q, to_d;
  logic           capture, commit;
  logic [7:0]     sel;
  logic [3:0]     dec_nibble;
  logic           dec_ok, dec_blank;

  // Decode the latched sample so a change during CAPTURE cannot corrupt the slot.
  seg7_glyph_decode u_glyph_decode (
    .seg7   (cap_seg_q),
    .nibble (dec_nibble),
    .ok     (dec_ok),
    .blank  (dec_blank)
  );

  // Input register and stability count of consecutive identical samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q   <= AN_NONE;
      seg_q  <= ~SEG_BLANK;
      stab_q <= 8'd0;
    end else begin
      an_q  <= an;
      seg_q <= seg7;
      if ({an, seg7} != {an_q, seg_q}) begin
        stab_q <= 8'd1;
      end else if (stab_q < StabMax) begin
        stab_q <= stab_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (an_q != AN_NONE) state_d = StSettle;
      end
      StSettle: begin
        if (an_q == AN_NONE) begin
          state_d = StIdle;
        end else if (stab_q == StabMax) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        capture = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if ({an_q, seg_q} != {cap_an_q, cap_seg_q}) begin
          state_d = (an_q == AN_NONE) ? StIdle : StSettle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sel         = ~cap_an_q;
    commit      = (seen_q == 8'hFF);
    seen_d      = commit ? 8'h00 : seen_q;
    buf_nib_d   = buf_nib_q;
    buf_ok_d    = buf_ok_q;
    buf_blank_d = buf_blank_q;
    err_d       = 1'b0;
    to_d        = (to_q < ToMax) ? to_q + ToW'(1) : to_q;
    if (capture) begin
      to_d = '0;
      if ($onehot(sel)) begin
        for (int i = 0; i < 8; i++) begin
          if (sel[i]) begin
            buf_nib_d[4*i +: 4] = dec_nibble;
            buf_ok_d[i]         = dec_ok;
            buf_blank_d[i]      = dec_blank;
            seen_d[i]           = 1'b1;
          end
        end
        err_d = !dec_ok && !dec_blank;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cap_an_q     <= AN_NONE;
      cap_seg_q    <= ~SEG_BLANK;
      seen_q       <= 8'h00;
      buf_nib_q    <= 32'h0;
      buf_ok_q     <= 8'h00;
      buf_blank_q  <= 8'h00;
      digits_q     <= 32'h0;
      ok_q         <= 8'h00;
      blank_q      <= 8'h00;
      frame_done_q <= 1'b0;
      decode_err_q <= 1'b0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      seen_q       <= seen_d;
      buf_nib_q    <= buf_nib_d;
      buf_ok_q     <= buf_ok_d;
      buf_blank_q  <= buf_blank_d;
      frame_done_q <= commit;
      decode_err_q <= err_d;
      to_q         <= to_d;
      if (state_q == StSettle && state_d == StCapture) begin
        cap_an_q  <= an_q;
        cap_seg_q <= seg_q;
      end
      if (commit) begin
        digits_q <= buf_nib_q;
        ok_q     <= buf_ok_q;
        blank_q  <= buf_blank_q;
      end
    end
  end

`ifdef SEG7_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= 8'h00;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign digits      = digits_q;
  assign digit_ok    = ok_q;
  assign digit_blank = blank_q;
  assign frame_done  = frame_done_q;
  assign decode_err  = decode_err_q;
  assign scan_stall  = (to_q == ToMax);

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans frames on the bus and checks the
// rebuilt digits, flags, pulses and stall indication.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [6:0]  seg7 = 7'h7F;
  logic [31:0] digits;
  logic [7:0]  digit_ok, digit_blank;
  logic        frame_done, decode_err, scan_stall;
`ifdef SEG7_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int n_pass = 0;
  int n_total = 0;
  int fd_cnt = 0;
  int de_cnt = 0;
  int fd0, de0;

  // Active-high glyphs for hex 0..F.
  logic [6:0] gly [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg7        (seg7),
    .digits      (digits),
    .digit_ok    (digit_ok),
    .digit_blank (digit_blank),
    .frame_done  (frame_done),
    .decode_err  (decode_err),
    .scan_stall  (scan_stall)
`ifdef SEG7_ERR_COUNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (decode_err === 1'b1) de_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    an    = 8'hFF;
    seg7  = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic show(input logic [7:0] a, input logic [6:0] s, input int n);
    an   = a;
    seg7 = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show_digit(input int i, input logic [3:0] v, input int n);
    logic [7:0] onehot;
    onehot = 8'd1 << i;
    show(~onehot, ~gly[v], n);
  endtask

  task automatic scan(input logic [31:0] v, input logic [7:0] mask);
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) show_digit(i, v[4*i +: 4], 8);
    end
    show(8'hFF, 7'h7F, 6);
  endtask

  task automatic snap();
    fd0 = fd_cnt;
    de0 = de_cnt;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (digits !== 32'h0) $display("FAIL reset_digits: got %h want 0", digits);
    else n_pass++;
    n_total++;
    if (digit_ok !== 8'h00) $display("FAIL reset_ok: got %h want 00", digit_ok);
    else n_pass++;
    n_total++;
    if (digit_blank !== 8'h00) $display("FAIL reset_blank: got %h want 00", digit_blank);
    else n_pass++;
    n_total++;
    if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done);
    else n_pass++;
    n_total++;
    if (decode_err !== 1'b0) $display("FAIL reset_decode_err: got %b want 0", decode_err);
    else n_pass++;
    n_total++;
    if (scan_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", scan_stall);
    else n_pass++;
  endtask

  task automatic test_scan();
    do_reset();
    snap();
    scan(32'h12345678, 8'hFF);
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL scan_frames: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
    n_total++;
    if (de_cnt - de0 !== 0) $display("FAIL scan_errs: got %0d want 0", de_cnt - de0);
    else n_pass++;
    n_total++;
    if (digits !== 32'h12345678) $display("FAIL scan_digits: got %h want 12345678", digits);
    else n_pass++;
    n_total++;
    if (digit_ok !== 8'hFF) $display("FAIL scan_ok: got %h want FF", digit_ok);
    else n_pass++;
    n_total++;
    if (digit_blank !== 8'h00) $display("FAIL scan_blank: got %h want 00", digit_blank);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    snap();
    scan(32'hFEDCBA90, 8'hFF);
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL b2b_frames: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
    n_total++;
    if (digits !== 32'hFEDCBA90) $display("FAIL b2b_digits: got %h want FEDCBA90", digits);
    else n_pass++;
    n_total++;
    if (digit_ok !== 8'hFF) $display("FAIL b2b_ok: got %h want FF", digit_ok);
    else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    snap();
    show_digit(0, 4'h1, 3);
    show_digit(0, 4'h2, 6);
    scan(32'h76543210, 8'hFE);
    n_total++;
    if (digits !== 32'h76543212) $display("FAIL glitch_digits: got %h want 76543212", digits);
    else n_pass++;
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL glitch_frames: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
    n_total++;
    if (de_cnt - de0 !== 0) $display("FAIL glitch_errs: got %0d want 0", de_cnt - de0);
    else n_pass++;
  endtask

  task automatic test_blank_illegal();
    logic [31:0] v;
    logic [7:0]  onehot;
    logic [6:0]  s;
    v = 32'h12345678;
    do_reset();
    snap();
    for (int i = 0; i < 8; i++) begin
      onehot = 8'd1 << i;
      if (i == 2) s = 7'h7F;
      else if (i == 5) s = ~7'h49;
      else s = ~gly[v[4*i +: 4]];
      show(~onehot, s, 8);
    end
    show(8'hFF, 7'h7F, 6);
    n_total++;
    if (digit_blank !== 8'h04) $display("FAIL bi_blank: got %h want 04", digit_blank);
    else n_pass++;
    n_total++;
    if (digit_ok !== 8'hDB) $display("FAIL bi_ok: got %h want DB", digit_ok);
    else n_pass++;
    n_total++;
    if (digits !== 32'h12045078) $display("FAIL bi_digits: got %h want 12045078", digits);
    else n_pass++;
    n_total++;
    if (de_cnt - de0 !== 1) $display("FAIL bi_errs: got %0d want 1", de_cnt - de0);
    else n_pass++;
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL bi_frames: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_multi_hot();
    do_reset();
    snap();
    show(8'b1111_0011, ~gly[1], 8);
    show(8'hFF, 7'h7F, 4);
    n_total++;
    if (de_cnt - de0 !== 1) $display("FAIL mh_errs: got %0d want 1", de_cnt - de0);
    else n_pass++;
    n_total++;
    if (digits !== 32'h0) $display("FAIL mh_digits: got %h want 0", digits);
    else n_pass++;
    // Digits 2 and 3 must still be missing from the frame.
    scan(32'h89ABCDEF, 8'hF3);
    n_total++;
    if (fd_cnt - fd0 !== 0) $display("FAIL mh_no_frame: got %0d want 0", fd_cnt - fd0);
    else n_pass++;
    scan(32'h89ABCDEF, 8'h0C);
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL mh_frame: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
    n_total++;
    if (digits !== 32'h89ABCDEF) $display("FAIL mh_final: got %h want 89ABCDEF", digits);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    scan(32'h0F1E2D3C, 8'hFF);
    show(8'hFF, 7'h7F, 84);
    n_total++;
    if (scan_stall !== 1'b0) $display("FAIL stall_early: got %b want 0", scan_stall);
    else n_pass++;
    show(8'hFF, 7'h7F, 20);
    n_total++;
    if (scan_stall !== 1'b1) $display("FAIL stall_set: got %b want 1", scan_stall);
    else n_pass++;
    n_total++;
    if (digits !== 32'h0F1E2D3C) $display("FAIL stall_hold: got %h want 0F1E2D3C", digits);
    else n_pass++;
    show_digit(3, 4'h9, 8);
    n_total++;
    if (scan_stall !== 1'b0) $display("FAIL stall_clear: got %b want 0", scan_stall);
    else n_pass++;
    n_total++;
    if (digits !== 32'h0F1E2D3C) $display("FAIL stall_keep: got %h want 0F1E2D3C", digits);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    scan(32'h13579BDF, 8'h1F);
    do_reset();
    n_total++;
    if (digits !== 32'h0) $display("FAIL rm_digits0: got %h want 0", digits);
    else n_pass++;
    snap();
    scan(32'h2468ACE0, 8'h7F);
    n_total++;
    if (fd_cnt - fd0 !== 0) $display("FAIL rm_partial: got %0d want 0", fd_cnt - fd0);
    else n_pass++;
    scan(32'h2468ACE0, 8'h80);
    n_total++;
    if (fd_cnt - fd0 !== 1) $display("FAIL rm_frame: got %0d want 1", fd_cnt - fd0);
    else n_pass++;
    n_total++;
    if (digits !== 32'h2468ACE0) $display("FAIL rm_digits: got %h want 2468ACE0", digits);
    else n_pass++;
    n_total++;
    if (digit_ok !== 8'hFF) $display("FAIL rm_ok: got %h want FF", digit_ok);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_back_to_back();
    test_glitch();
    test_blank_illegal();
    test_multi_hot();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the scanned anode/segment bus (an, seg7) and reconstructs the 8 displayed hex digits.
- Flags blank, illegal and ghosted patterns, and reports completed scan frames.
- Used in-system for self-check of the acc/alu display path and by benches as a display monitor.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples of {an,seg7} required before a digit is accepted (range 1..255).
- TIMEOUT_CYCLES, 65535: cycles without any accepted digit before scan_stall asserts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- an  in  8  anode select; active-low one-hot; an[i]=0 selects digit i
- seg7  in  7  segments {g,f,e,d,c,b,a}; active-low (0 = lit)
- digits  out  32  last complete frame; nibble i = digits[4i+3:4i]
- digit_ok  out  8  per digit: 1 = valid hex glyph in last frame
- digit_blank  out  8  per digit: 1 = all segments off in last frame
- frame_done  out  1  one-cycle pulse when digits/digit_ok/digit_blank update
- decode_err  out  1  one-cycle pulse on an accepted illegal glyph or a multi-hot anode
- scan_stall  out  1  level; no digit accepted for TIMEOUT_CYCLES cycles

Behaviour:
- Reset: all outputs 0; internal capture buffers, seen-mask and counters cleared; FSM to IDLE.
- Inputs are registered once before use (1 cycle input latency).
- Stability counter:
  - Increments while registered {an,seg7} equals the previous sample.
  - Reloads to 1 on any change.
  - Saturates at STABLE_CYCLES.
- FSM:
  - IDLE: wait while an==8'hFF. Go to SETTLE on any other value.
  - SETTLE: on a sample change, stay in SETTLE. When the count reaches STABLE_CYCLES, go to CAPTURE.
  - CAPTURE: one cycle.
    - One-hot anode: decode the glyph into buffer slot i and set seen[i].
    - Multi-hot anode: pulse decode_err and write nothing.
    - Then go to HOLD.
  - HOLD: wait until {an,seg7} changes. Return to IDLE if an==8'hFF, otherwise go to SETTLE. A digit is captured at most once per dwell.
- Decode: compare ~seg7 against 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 (hex digits 0..F).
  - 00 gives blank: ok=0, blank=1, nibble 0.
  - Any other pattern gives ok=0, blank=0, nibble 0, and pulses decode_err.
- Frame completion:
  - When seen==8'hFF after a capture, the buffers are copied to the outputs on the next cycle and frame_done pulses.
  - seen clears in the same cycle as the copy.
  - A re-capture of the same digit before the frame completes overwrites its slot (latest wins).
- Timeout counter:
  - Counts up every cycle and clears on each CAPTURE; it saturates.
  - scan_stall asserts when the counter reaches TIMEOUT_CYCLES and deasserts on the next CAPTURE.
  - Outputs keep their last frame during a stall.
- Simultaneous events:
  - A CAPTURE that completes a frame and carries an illegal glyph pulses both decode_err and frame_done (frame_done one cycle later).
- Reset mid-frame discards the partial frame.

Optional Feature:
- Macro: SEG7_ERR_COUNT_EN.
- When defined:
  - Adds output err_count [7:0], a saturating count of decode_err pulses.
  - It clears on reset and holds at 8'hFF.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16-entry glyph constant table (active-high encoding), SEG_BLANK=7'h00, AN_NONE=8'hFF;
  - FSM state typedef {IDLE, SETTLE, CAPTURE, HOLD}.
- One natural sub-module: seg7_glyph_decode, combinational, with ports seg7 in, and nibble/ok/blank out.
  - The package table is shared with the display driver so both ends agree.

Test Plan:
- Scan 8 digits showing 0x12345678 (digit i = i+1 reversed order ok), each held 8 cycles, STABLE_CYCLES=4 -> one frame_done; digits=32'h12345678; digit_ok=8'hFF; no decode_err.
- Glitch: hold a digit 3 cycles, change seg7, then hold 6 cycles -> only the second glyph is captured; no extra capture.
- Digit 2 shows seg7=~7'h00, digit 5 shows ~7'h49 -> digit_blank=8'h04; digit_ok bits 2 and 5 clear; one decode_err pulse.
- an=8'b1111_0011 held 8 cycles -> decode_err pulse; seen unchanged; no frame_done.
- TIMEOUT_CYCLES=100 with an=8'hFF for 150 cycles -> scan_stall high from cycle 100; clears on the next capture; digits retained.
- Reset asserted after 5 of 8 digits, then a full rescan -> frame_done only after all 8 new digits; outputs show the new frame only.
